// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and address check for the data memory responder
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int DWORD_BYTES = 8;
   localparam int ADDR_W      = 64;

   // off is the byte offset from the base; negative offsets wrap to huge indices
   function automatic logic addr_err(input logic [ADDR_W-1:0] off,
                                     input int unsigned       depth);
      return (off[2:0] != 3'b000) || (off[ADDR_W-1:3] >= 61'(depth));
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - doubleword RAM with byte write enables and a registered read port
module dmem_array #(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [7:0]       be,
   input  logic [IDX_W-1:0] addr,
   input  logic [63:0]      wdata,
   output logic [63:0]      rdata
);

   logic [63:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 8; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - LDUR/STUR responder with valid/ready channels and fixed access latency
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH       = 256,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [63:0]            req_wdata,
   input  logic [DWORD_BYTES-1:0] req_bmask,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [63:0]            rsp_rdata,
   output logic                   rsp_err
);

   localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   state_t state, state_nxt;

   logic                   armed;
   logic [3:0]             wait_cnt;
   logic                   cap_write;
   logic [ADDR_W-1:0]      cap_addr;
   logic [63:0]            cap_wdata;
   logic [DWORD_BYTES-1:0] cap_bmask;
   logic                   err_q;

   logic                   accept;
   logic                   acc_go;
   logic                   acc_write;
   logic [ADDR_W-1:0]      acc_addr;
   logic [63:0]            acc_wdata;
   logic [DWORD_BYTES-1:0] acc_bmask;
   logic [ADDR_W-1:0]      acc_off;
   logic                   acc_err;
   logic [IDX_W-1:0]       acc_idx;
   logic [63:0]            ram_rdata;

   // armed keeps req_ready low until the first edge after reset release
   assign req_ready = armed && (state == IDLE);
   assign accept    = req_valid && req_ready;

   // With no wait states the access happens on the accept edge, so use the live inputs
   assign acc_go    = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (wait_cnt == WAIT_LAST));
   assign acc_write = (state == IDLE) ? req_write : cap_write;
   assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
   assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
   assign acc_bmask = (state == IDLE) ? req_bmask : cap_bmask;

   assign acc_off = acc_addr - BASE_ADDR;
   assign acc_err = addr_err(acc_off, DEPTH);
   assign acc_idx = acc_off[IDX_W+2:3];

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (acc_go && !acc_err),
      .we    (acc_write),
      .be    (acc_bmask),
      .addr  (acc_idx),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT: if (wait_cnt == WAIT_LAST) state_nxt = RESP;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         armed     <= 1'b0;
         wait_cnt  <= 4'd0;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_bmask <= '0;
         err_q     <= 1'b0;
      end else begin
         state    <= state_nxt;
         armed    <= 1'b1;
         wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
         if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_bmask <= req_bmask;
         end
         if (acc_go) err_q <= acc_err;
      end
   end

   // The array read register only moves on a load access, so it is stable throughout RESP
   assign rsp_valid = (state == RESP);
   assign rsp_err   = (state == RESP) && err_q;
   assign rsp_rdata = ((state == RESP) && !cap_write && !err_q) ? ram_rdata : 64'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_bmask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   data_mem_responder #(
      .DEPTH       (256),
      .WAIT_CYCLES (2),
      .BASE_ADDR   (64'h0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_bmask (req_bmask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called and returns at 1ns after a rising edge; garbles inputs after acceptance
   task automatic do_access(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                            input logic [7:0] bm, output logic [63:0] rd, output logic er,
                            output int lat, output logic rdy_after);
      int guard;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_bmask = bm;
      req_valid = 1'b1;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = ~wr;
      req_addr  = 64'h13;
      req_wdata = ~wd;
      req_bmask = ~bm;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge clk); #1;
      rdy_after = req_ready;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: req_ready=%b rsp_valid=%b expected 0/0", req_ready, rsp_valid);
         end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b0 || rsp_rdata !== 64'h0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: req_ready=%b rdata=%h err=%b expected 0/0/0", req_ready, rsp_rdata, rsp_err);
      end
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_edge: req_ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_store_load;
      logic [63:0] rd;
      logic er, ra;
      int lat;
      do_access(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, rd, er, lat, ra);
      n_checks++;
      if (lat !== 3 || er !== 1'b0 || rd !== 64'h0) begin
         n_fail++;
         $display("FAIL store_ack: lat=%0d err=%b rdata=%h expected 3/0/0", lat, er, rd);
      end
      n_checks++;
      if (ra !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_handshake: got %b expected 1", ra);
      end
      do_access(1'b0, 64'h10, 64'h0, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (lat !== 3 || er !== 1'b0 || rd !== 64'hDEADBEEF_CAFEF00D) begin
         n_fail++;
         $display("FAIL load_after_store: lat=%0d err=%b rdata=%h expected 3/0/deadbeefcafef00d", lat, er, rd);
      end
   endtask

   task automatic test_byte_mask;
      logic [63:0] rd;
      logic er, ra;
      int lat;
      do_access(1'b1, 64'h10, 64'h11223344_55667788, 8'h0F, rd, er, lat, ra);
      do_access(1'b0, 64'h10, 64'h0, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (er !== 1'b0 || rd !== 64'hDEADBEEF_55667788) begin
         n_fail++;
         $display("FAIL byte_mask_low: err=%b rdata=%h expected 0/deadbeef55667788", er, rd);
      end
      do_access(1'b1, 64'h10, 64'hFF00FF00_FF00FF00, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (er !== 1'b0 || lat !== 3) begin
         n_fail++;
         $display("FAIL zero_mask_ack: err=%b lat=%0d expected 0/3", er, lat);
      end
      do_access(1'b0, 64'h10, 64'h0, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (rd !== 64'hDEADBEEF_55667788) begin
         n_fail++;
         $display("FAIL zero_mask_nowrite: rdata=%h expected deadbeef55667788", rd);
      end
   endtask

   task automatic test_errors;
      logic [63:0] rd;
      logic er, ra;
      int lat;
      do_access(1'b1, 64'h0, 64'h01234567_89ABCDEF, 8'hFF, rd, er, lat, ra);
      do_access(1'b0, 64'h13, 64'h0, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (er !== 1'b1 || rd !== 64'h0 || lat !== 3) begin
         n_fail++;
         $display("FAIL misaligned_load: err=%b rdata=%h lat=%0d expected 1/0/3", er, rd, lat);
      end
      do_access(1'b1, 64'h800, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, rd, er, lat, ra);
      n_checks++;
      if (er !== 1'b1 || rd !== 64'h0 || lat !== 3) begin
         n_fail++;
         $display("FAIL range_store: err=%b rdata=%h lat=%0d expected 1/0/3", er, rd, lat);
      end
      do_access(1'b0, 64'h0, 64'h0, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (er !== 1'b0 || rd !== 64'h01234567_89ABCDEF) begin
         n_fail++;
         $display("FAIL index0_intact: err=%b rdata=%h expected 0/0123456789abcdef", er, rd);
      end
      do_access(1'b1, 64'h7F8, 64'h0F0F0F0F_A5A5A5A5, 8'hFF, rd, er, lat, ra);
      do_access(1'b0, 64'h7F8, 64'h0, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (er !== 1'b0 || rd !== 64'h0F0F0F0F_A5A5A5A5) begin
         n_fail++;
         $display("FAIL last_index: err=%b rdata=%h expected 0/0f0f0f0fa5a5a5a5", er, rd);
      end
      do_access(1'b0, 64'hFFFFFFFF_FFFFFFF8, 64'h0, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (er !== 1'b1 || rd !== 64'h0) begin
         n_fail++;
         $display("FAIL wrapped_addr: err=%b rdata=%h expected 1/0", er, rd);
      end
   endtask

   task automatic test_backpressure;
      int guard;
      rsp_ready = 1'b0;
      req_write = 1'b0;
      req_addr  = 64'h10;
      req_bmask = 8'h00;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      guard = 0;
      while (rsp_valid !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_55667788 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold: valid=%b rdata=%h err=%b ready=%b expected 1/deadbeef55667788/0/0",
                     rsp_valid, rsp_rdata, rsp_err, req_ready);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure_release: valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset_mid_op;
      logic [63:0] rd;
      logic er, ra;
      int lat;
      do_access(1'b1, 64'h20, 64'h0BADF00D_12345678, 8'hFF, rd, er, lat, ra);
      req_write = 1'b1;
      req_addr  = 64'h20;
      req_wdata = 64'hAAAAAAAA_AAAAAAAA;
      req_bmask = 8'hFF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_wait: valid=%b ready=%b expected 0/0", rsp_valid, req_ready);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      do_access(1'b0, 64'h20, 64'h0, 8'h00, rd, er, lat, ra);
      n_checks++;
      if (er !== 1'b0 || rd !== 64'h0BADF00D_12345678) begin
         n_fail++;
         $display("FAIL store_dropped: err=%b rdata=%h expected 0/0badf00d12345678", er, rd);
      end
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 64'h0;
      req_wdata = 64'h0;
      req_bmask = 8'h00;
      rsp_ready = 1'b1;
      test_reset();
      test_store_load();
      test_byte_mask();
      test_errors();
      test_backpressure();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
